// File: rtl/sma_fb_pkg.sv
// Shared sizing helpers and legal parameter ranges for the streaming moving-average filter.
// Consumers: sma_fb_stream (top) and sma_hist_ring.
package sma_fb_pkg;

  localparam int DATA_W_MIN     = 4;
  localparam int DATA_W_MAX     = 32;
  localparam int LOG2_DEPTH_MIN = 1;
  localparam int LOG2_DEPTH_MAX = 8;

  // Accumulator width: a full window of extreme samples sums without overflow.
  function automatic int acc_w(input int data_w, input int log2_depth);
    return data_w + log2_depth;
  endfunction

  // Half of one LSB of the shifted result, used for round-half-up.
  function automatic int round_half(input int log2_depth);
    return 1 << (log2_depth - 1);
  endfunction

endpackage

// File: rtl/sma_hist_ring.sv
// DEPTH x DATA_W sample history ring with internal write pointer.
// The old sample is read combinationally before the write lands at the clock edge.
module sma_hist_ring
  import sma_fb_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int LOG2_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic                     clear,
  input  logic signed [DATA_W-1:0] wdata,
  output logic signed [DATA_W-1:0] old
);

  localparam int DEPTH = 1 << LOG2_DEPTH;

  logic signed [DATA_W-1:0] hist [DEPTH];
  logic [LOG2_DEPTH-1:0]    wp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp <= '0;
      for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
    end else if (clear) begin
      wp <= '0;
      for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
    end else if (we) begin
      hist[wp] <= wdata;
      wp       <= wp + 1'b1;
    end
  end

  assign old = hist[wp];

endmodule

// File: rtl/sma_fb_stream.sv
// Streaming moving average over 2**LOG2_DEPTH signed samples using a feedback accumulator.
// Optional build macro SMA_FB_STREAM_ROUND_EN selects round-half-up instead of floor.
module sma_fb_stream
  import sma_fb_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int LOG2_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] x,
  input  logic                     clear,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] y,
  output logic                     warm
);

  localparam int ACC_W = acc_w(DATA_W, LOG2_DEPTH);
  localparam int DEPTH = 1 << LOG2_DEPTH;

  if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX) begin : g_bad_data_w
    $error("sma_fb_stream: DATA_W out of range");
  end
  if (LOG2_DEPTH < LOG2_DEPTH_MIN || LOG2_DEPTH > LOG2_DEPTH_MAX) begin : g_bad_log2_depth
    $error("sma_fb_stream: LOG2_DEPTH out of range");
  end

  // Handshake: valid-only stream. A sample is taken on any edge with in_valid=1
  // and clear=0; out_valid pulses one cycle later. There is no backpressure.
  logic accept;
  assign accept = in_valid & ~clear;

  logic signed [DATA_W-1:0] old;
  logic signed [ACC_W-1:0]  acc, acc_n;
  logic [LOG2_DEPTH:0]      fill;
  logic signed [DATA_W-1:0] y_n;

  sma_hist_ring #(
    .DATA_W     (DATA_W),
    .LOG2_DEPTH (LOG2_DEPTH)
  ) u_ring (
    .clk   (clk),
    .rst   (rst),
    .we    (accept),
    .clear (clear),
    .wdata (x),
    .old   (old)
  );

  assign acc_n = acc - ACC_W'(old) + ACC_W'(x);

`ifdef SMA_FB_STREAM_ROUND_EN
  logic signed [ACC_W:0] rsum, rshift;
  logic                  unused_rshift_hi;
  assign rsum             = (ACC_W+1)'(acc_n) + (ACC_W+1)'(round_half(LOG2_DEPTH));
  assign rshift           = rsum >>> LOG2_DEPTH;
  assign y_n              = {rshift[ACC_W], rshift[DATA_W-2:0]};
  assign unused_rshift_hi = ^rshift[ACC_W-1:DATA_W-1];
`else
  logic signed [ACC_W-1:0] fshift;
  logic                    unused_fshift_hi;
  assign fshift           = acc_n >>> LOG2_DEPTH;
  assign y_n              = {fshift[ACC_W-1], fshift[DATA_W-2:0]};
  assign unused_fshift_hi = ^fshift[ACC_W-2:DATA_W-1];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc       <= '0;
      fill      <= '0;
      y         <= '0;
      out_valid <= 1'b0;
    end else if (clear) begin
      acc       <= '0;
      fill      <= '0;
      y         <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= accept;
      if (accept) begin
        acc <= acc_n;
        y   <= y_n;
        if (fill != (LOG2_DEPTH+1)'(DEPTH)) fill <= fill + 1'b1;
      end
    end
  end

  assign warm = (fill == (LOG2_DEPTH+1)'(DEPTH));

endmodule

// File: tb/tb_sma_fb_stream.sv
// Directed self-checking bench for sma_fb_stream at LOG2_DEPTH=2 and LOG2_DEPTH=8.
// Expected values are hand-computed; rounding-dependent ones follow SMA_FB_STREAM_ROUND_EN.
module tb_sma_fb_stream;

  logic               clk = 1'b0;
  logic               rst;
  logic               clear;
  logic               in_valid, valid8;
  logic signed [15:0] x, x8;
  logic               out_valid, out_valid8;
  logic signed [15:0] y, y8;
  logic               warm, warm8;

  int vectors    = 0;
  int miscompares = 0;

  // clock / reset
  always #5 clk = ~clk;

  sma_fb_stream #(.DATA_W(16), .LOG2_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .clear(clear),
    .out_valid(out_valid), .y(y), .warm(warm)
  );

  sma_fb_stream #(.DATA_W(16), .LOG2_DEPTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(valid8), .x(x8), .clear(clear),
    .out_valid(out_valid8), .y(y8), .warm(warm8)
  );

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled at the same point.
  task automatic drive(input logic v, input int xv, input logic c);
    in_valid = v;
    x        = 16'(xv);
    clear    = c;
    valid8   = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drive8(input int xv);
    in_valid = 1'b0;
    clear    = 1'b0;
    valid8   = 1'b1;
    x8       = 16'(xv);
    @(posedge clk);
    #1;
  endtask

  task automatic check_main(input string tag, input int ey, input int ev, input int ew);
    check({tag, ".y"}, int'(y), ey);
    check({tag, ".out_valid"}, int'(out_valid), ev);
    check({tag, ".warm"}, int'(warm), ew);
  endtask

  task automatic reset_pulse();
    #2 rst = 1'b0;
    #1;
    check_main("rst_async", 0, 0, 0);
    check("rst_async.y8", int'(y8), 0);
    @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; clear = 1'b0; in_valid = 1'b0; valid8 = 1'b0; x = '0; x8 = '0;
    repeat (2) @(posedge clk);
    #1;
    check_main("reset", 0, 0, 0);
    check("reset.warm8", int'(warm8), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    drive(1, 8, 0);   check_main("first8", 2, 1, 0);

    // Reset asserted mid-stream, then recovery without a flush.
    drive(1, 100, 0);
    drive(1, 100, 0);
    in_valid = 1'b0;
    reset_pulse();
    drive(1, 8, 0);   check_main("post_rst8", 2, 1, 0);
    drive(0, 0, 0);   check_main("post_rst_idle", 2, 0, 0);

    // Step response and warm-up.
    drive(0, 0, 1);   check_main("clr0", 0, 0, 0);
    drive(1, 100, 0); check_main("step1", 25, 1, 0);
    drive(1, 100, 0); check_main("step2", 50, 1, 0);
    drive(1, 100, 0); check_main("step3", 75, 1, 0);
    drive(1, 100, 0); check_main("step4", 100, 1, 1);
    drive(1, 100, 0); check_main("step5", 100, 1, 1);

    // Sign handling / rounding from reset.
    in_valid = 1'b0;
    reset_pulse();
`ifdef SMA_FB_STREAM_ROUND_EN
    drive(1, -2, 0);  check_main("neg2", 0, 1, 0);
`else
    drive(1, -2, 0);  check_main("neg2", -1, 1, 0);
`endif

    // Gaps between samples.
    drive(0, 0, 1);
    drive(1, 40, 0);  check_main("gap_s1", 10, 1, 0);
    drive(0, 0, 0);   check_main("gap_i1", 10, 0, 0);
    drive(0, 0, 0);   check_main("gap_i2", 10, 0, 0);
    drive(1, 80, 0);  check_main("gap_s2", 30, 1, 0);
    drive(0, 0, 0);   check_main("gap_end", 30, 0, 0);

    // Clear wins over a simultaneous sample.
    drive(0, 0, 1);
    for (int i = 0; i < 4; i++) drive(1, 40, 0);
    check_main("prewarm", 40, 1, 1);
    drive(1, 400, 1); check_main("clr_prio", 0, 0, 0);
    drive(1, 40, 0);  check_main("after_clr", 10, 1, 0);

    // Extremes across pointer wrap, depth 4.
    drive(0, 0, 1);
    for (int i = 0; i < 8; i++) drive(1, 32767, 0);
    check_main("max4", 32767, 1, 1);
    drive(1, -32768, 0); check_main("min4_1", 16383, 1, 1);
`ifdef SMA_FB_STREAM_ROUND_EN
    drive(1, -32768, 0); check_main("min4_2", 0, 1, 1);
    drive(1, -32768, 0); check_main("min4_3", -16384, 1, 1);
`else
    drive(1, -32768, 0); check_main("min4_2", -1, 1, 1);
    drive(1, -32768, 0); check_main("min4_3", -16385, 1, 1);
`endif
    drive(1, -32768, 0); check_main("min4_4", -32768, 1, 1);

    // Extremes, depth 256.
    drive(0, 0, 1);
    for (int k = 1; k <= 256; k++) begin
      drive8(32767);
      if (k == 255) check("max8_pre.warm8", int'(warm8), 0);
    end
    check("max8.y8", int'(y8), 32767);
    check("max8.warm8", int'(warm8), 1);
    check("max8.out_valid8", int'(out_valid8), 1);
    for (int k = 1; k <= 256; k++) begin
      drive8(-32768);
      if (k == 64)  check("min8_64.y8", int'(y8), 16383);
`ifdef SMA_FB_STREAM_ROUND_EN
      if (k == 128) check("min8_128.y8", int'(y8), 0);
      if (k == 192) check("min8_192.y8", int'(y8), -16384);
`else
      if (k == 128) check("min8_128.y8", int'(y8), -1);
      if (k == 192) check("min8_192.y8", int'(y8), -16385);
`endif
    end
    check("min8.y8", int'(y8), -32768);
    check("min8.warm8", int'(warm8), 1);
    valid8 = 1'b0;
    @(posedge clk);
    #1;
    check("idle8.out_valid8", int'(out_valid8), 0);
    check("idle8.y8", int'(y8), -32768);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
